// File: rtl/branch_cond_unit_pkg.sv
// rtl/branch_cond_unit_pkg.sv - shared condition codes, flag indices and FSM states
package branch_cond_unit_pkg;

   // Condition code encodings carried on br_cc
   typedef enum logic [3:0] {
      CC_AL = 4'd0,
      CC_EQ = 4'd1,
      CC_NE = 4'd2,
      CC_CS = 4'd3,
      CC_CC = 4'd4,
      CC_MI = 4'd5,
      CC_PL = 4'd6,
      CC_VS = 4'd7,
      CC_VC = 4'd8,
      CC_HI = 4'd9,
      CC_LS = 4'd10,
      CC_GE = 4'd11,
      CC_LT = 4'd12,
      CC_GT = 4'd13,
      CC_LE = 4'd14,
      CC_NV = 4'd15
   } cc_e;

   // Bit positions inside the 4-bit flags word
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Branch unit control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// rtl/branch_cond_unit_cond_eval.sv - combinational condition-code evaluator
module cond_eval
   import branch_cond_unit_pkg::*;
(
   input  logic [3:0] cc,
   input  logic [3:0] flags,
   output logic       taken
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Decode the condition code against the current flags
   always_comb begin
      taken = 1'b0;
      case (cc_e'(cc))
         CC_AL: taken = 1'b1;
         CC_EQ: taken = z;
         CC_NE: taken = ~z;
         CC_CS: taken = c;
         CC_CC: taken = ~c;
         CC_MI: taken = n;
         CC_PL: taken = ~n;
         CC_VS: taken = v;
         CC_VC: taken = ~v;
         CC_HI: taken = c & ~z;
         CC_LS: taken = ~c | z;
         CC_GE: taken = (n == v);
         CC_LT: taken = (n != v);
         CC_GT: taken = ~z & (n == v);
         CC_LE: taken = z | (n != v);
         CC_NV: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - branch resolution FSM with redirect, flush and statistics
module branch_cond_unit
   import branch_cond_unit_pkg::*;
#(
   parameter int AW           = 8,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNTW         = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [3:0]      br_cc,
   input  logic [AW-1:0]   br_target,
   input  logic [3:0]      flags_in,
   input  logic            flag_pending,
   input  logic            kill,
   output logic            redirect_valid,
   output logic [AW-1:0]   redirect_pc,
   output logic            flush,
   output logic            br_done,
   output logic            br_taken,
   output logic [CNTW-1:0] taken_cnt,
   output logic [CNTW-1:0] stall_cnt
);

   // Flush counter is preloaded with the number of remaining cycles after the first
   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

   state_e          state, state_nxt;
   logic [3:0]      cc_q, cc_nxt;
   logic [AW-1:0]   tgt_q, tgt_nxt;
   logic [3:0]      fcnt_q, fcnt_nxt;
   logic            rv_nxt, flush_nxt, done_nxt, taken_nxt;
   logic [AW-1:0]   rpc_nxt;
   logic [CNTW-1:0] tcnt_nxt, scnt_nxt;
   logic            cond_taken;

   cond_eval u_cond_eval (
      .cc    (cc_q),
      .flags (flags_in),
      .taken (cond_taken)
   );

   assign br_ready = (state == ST_IDLE);

   // Next-state and next-output decision for the branch FSM
   always_comb begin
      state_nxt = state;
      cc_nxt    = cc_q;
      tgt_nxt   = tgt_q;
      fcnt_nxt  = fcnt_q;
      rv_nxt    = 1'b0;
      rpc_nxt   = redirect_pc;
      done_nxt  = 1'b0;
      taken_nxt = 1'b0;
      tcnt_nxt  = taken_cnt;
      scnt_nxt  = stall_cnt;
      case (state)
         ST_IDLE: begin
            if (br_valid) begin
               cc_nxt    = br_cc;
               tgt_nxt   = br_target;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (kill) begin
               state_nxt = ST_IDLE;
            end else if (flag_pending) begin
               if (!(&stall_cnt)) begin
                  scnt_nxt = stall_cnt + CNTW'(1);
               end
            end else begin
               done_nxt  = 1'b1;
               taken_nxt = cond_taken;
               if (cond_taken) begin
                  state_nxt = ST_FLUSH;
                  rv_nxt    = 1'b1;
                  rpc_nxt   = tgt_q;
                  fcnt_nxt  = FLUSH_LAST;
                  if (!(&taken_cnt)) begin
                     tcnt_nxt = taken_cnt + CNTW'(1);
                  end
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_FLUSH: begin
            if (fcnt_q == 4'd0) begin
               state_nxt = ST_IDLE;
            end else begin
               fcnt_nxt = fcnt_q - 4'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      flush_nxt = (state_nxt == ST_FLUSH);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latched request, strobes and statistics counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cc_q           <= 4'd0;
         tgt_q          <= '0;
         fcnt_q         <= 4'd0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
         br_done        <= 1'b0;
         br_taken       <= 1'b0;
         taken_cnt      <= '0;
         stall_cnt      <= '0;
      end else begin
         cc_q           <= cc_nxt;
         tgt_q          <= tgt_nxt;
         fcnt_q         <= fcnt_nxt;
         redirect_valid <= rv_nxt;
         redirect_pc    <= rpc_nxt;
         flush          <= flush_nxt;
         br_done        <= done_nxt;
         br_taken       <= taken_nxt;
         taken_cnt      <= tcnt_nxt;
         stall_cnt      <= scnt_nxt;
      end
   end

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb/tb_branch_cond_unit.sv - scoreboard bench for branch_cond_unit
module tb_branch_cond_unit;

   localparam int AW = 8;
   localparam int FC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          br_valid = 1'b0;
   logic [3:0]    br_cc = 4'd0;
   logic [AW-1:0] br_target = '0;
   logic [3:0]    flags_in = 4'd0;
   logic          flag_pending = 1'b0;
   logic          kill = 1'b0;

   logic          br_ready, redirect_valid, flush, br_done, br_taken;
   logic [AW-1:0] redirect_pc;
   logic [15:0]   taken_cnt, stall_cnt;

   logic          br_ready2, redirect_valid2, flush2, br_done2, br_taken2;
   logic [AW-1:0] redirect_pc2;
   logic [1:0]    taken_cnt2, stall_cnt2;

   typedef struct packed {
      logic          taken;
      logic [AW-1:0] pc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   exp_taken = 0;
   int   exp_stall = 0;

   always #5 clk = ~clk;

   branch_cond_unit #(.AW(AW), .FLUSH_CYCLES(FC), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
      .br_cc(br_cc), .br_target(br_target), .flags_in(flags_in),
      .flag_pending(flag_pending), .kill(kill),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush), .br_done(br_done), .br_taken(br_taken),
      .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
   );

   branch_cond_unit #(.AW(AW), .FLUSH_CYCLES(FC), .CNTW(2)) dut_sat (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready2),
      .br_cc(br_cc), .br_target(br_target), .flags_in(flags_in),
      .flag_pending(flag_pending), .kill(kill),
      .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
      .flush(flush2), .br_done(br_done2), .br_taken(br_taken2),
      .taken_cnt(taken_cnt2), .stall_cnt(stall_cnt2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic ref_taken(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cc)
         4'd0:  return 1'b1;
         4'd1:  return z;
         4'd2:  return !z;
         4'd3:  return c;
         4'd4:  return !c;
         4'd5:  return n;
         4'd6:  return !n;
         4'd7:  return v;
         4'd8:  return !v;
         4'd9:  return c && !z;
         4'd10: return !c || z;
         4'd11: return n == v;
         4'd12: return n != v;
         4'd13: return !z && (n == v);
         4'd14: return z || (n != v);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sat3(input int x);
      return (x > 3) ? 3 : x;
   endfunction

   // Monitor: every resolution strobe is matched against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         if (br_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got br_done=1 expected no resolution");
            end else begin
               mon_e = exp_q.pop_front();
               check("br_taken", 32'(br_taken), 32'(mon_e.taken));
               check("redirect_valid", 32'(redirect_valid), 32'(mon_e.taken));
               if (mon_e.taken) check("redirect_pc", 32'(redirect_pc), 32'(mon_e.pc));
            end
         end else if (redirect_valid) begin
            checks++;
            errors++;
            $display("FAIL stray_redirect: got redirect_valid=1 expected 0 without br_done");
         end
      end
   end

   // Called #1 after a rising edge with the unit idle; returns with it idle again
   task automatic issue(input logic [3:0] cc, input logic [3:0] fl, input logic [AW-1:0] tgt,
                        input int pend, input logic exp_tk);
      int n;
      br_valid     = 1'b1;
      br_cc        = cc;
      br_target    = tgt;
      flags_in     = fl;
      flag_pending = (pend > 0);
      exp_q.push_back('{taken: exp_tk, pc: tgt});
      @(posedge clk); #1;
      br_valid = 1'b0;
      repeat (pend) begin
         @(posedge clk); #1;
      end
      flag_pending = 1'b0;
      @(posedge clk); #1;
      check("done_latency", 32'(br_done), 32'd1);
      exp_stall += pend;
      if (exp_tk) begin
         exp_taken++;
         n = 0;
         while (flush && n < 20) begin
            n++;
            @(posedge clk); #1;
         end
         check("flush_cycles", 32'(n), 32'(FC));
      end else begin
         check("no_flush", 32'(flush), 32'd0);
      end
      check("ready_after", 32'(br_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_ready", 32'(br_ready), 32'd1);
      check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_done", 32'(br_done), 32'd0);
      check("rst_taken", 32'(br_taken), 32'd0);
      check("rst_redirect_pc", 32'(redirect_pc), 32'd0);
      check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_release", 32'(br_ready), 32'd1);
      @(posedge clk); #1;

      // EQ taken with Z set
      issue(4'd1, 4'b0100, 8'hA5, 0, 1'b1);
      check("taken_cnt_eq", 32'(taken_cnt), 32'd1);

      // LT not taken with N==V
      issue(4'd12, 4'b1001, 8'h3C, 0, 1'b0);
      check("taken_cnt_lt", 32'(taken_cnt), 32'd1);

      // CS taken after three stall cycles
      issue(4'd3, 4'b0010, 8'h77, 3, 1'b1);
      check("stall_cnt", 32'(stall_cnt), 32'd3);
      check("taken_cnt_cs", 32'(taken_cnt), 32'd2);

      // Kill wins over a same-cycle resolution
      br_valid = 1'b1; br_cc = 4'd1; br_target = 8'h55; flags_in = 4'b0100; flag_pending = 1'b0;
      @(posedge clk); #1;
      br_valid = 1'b0;
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill_ready", 32'(br_ready), 32'd1);
      check("kill_done", 32'(br_done), 32'd0);
      check("kill_flush", 32'(flush), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("kill_taken_cnt", 32'(taken_cnt), 32'(exp_taken));

      // Reset asserted during the second flush cycle
      br_valid = 1'b1; br_cc = 4'd0; br_target = 8'hC3; flags_in = 4'b0000;
      exp_q.push_back('{taken: 1'b1, pc: 8'hC3});
      @(posedge clk); #1;
      br_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_flush1", 32'(flush), 32'd1);
      @(posedge clk); #1;
      check("pre_rst_flush2", 32'(flush), 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_flush", 32'(flush), 32'd0);
      check("mid_rst_redirect", 32'(redirect_valid), 32'd0);
      check("mid_rst_done", 32'(br_done), 32'd0);
      check("mid_rst_pc", 32'(redirect_pc), 32'd0);
      check("mid_rst_taken_cnt", 32'(taken_cnt), 32'd0);
      check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      exp_taken = 0;
      exp_stall = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(br_ready), 32'd1);
      repeat (3) begin
         @(negedge clk);
         check("post_rst_flush", 32'(flush), 32'd0);
      end
      @(posedge clk); #1;

      // Full condition table sweep, also drives the narrow counter into saturation
      for (int cc = 0; cc < 16; cc++) begin
         for (int f = 0; f < 16; f++) begin
            issue(4'(cc), 4'(f), {4'(cc), 4'(f)}, 0, ref_taken(4'(cc), 4'(f)));
         end
      end
      check("sweep_taken_cnt", 32'(taken_cnt), 32'(exp_taken));
      check("sweep_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      check("sat_taken_cnt", 32'(taken_cnt2), 32'(sat3(exp_taken)));

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
